// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter on the core IO bus.
//
// A small circular FIFO takes bytes that software writes to TXDATA. A
// serializer FSM drains the FIFO onto uart_tx. Every bit lasts DIVISOR+1
// clocks, and DIVISOR is latched at the start of each frame.
//
// Ports
//   clk           core clock; all state changes on the rising edge
//   reset         asynchronous, active-high; clears all state
//   io_addr       byte address; [7:2] selects the register
//   io_en/io_we   access strobe and write enable
//   io_data_write write data
//   io_data_read  read data, combinational from io_addr (io_en is ignored)
//   uart_tx       serial line, idle high, driven from a flop
//   irq_empty     registered; high when the FIFO is empty and the FSM is idle
//
// Registers (word offsets)
//   0x00 TXDATA  W: push [7:0]; reads as 0
//   0x04 STATUS  R: [0] full [1] empty [2] busy [3] overflow [7:4] count
//                W: any value clears overflow
//   0x08 DIVISOR R/W [15:0]
module io_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        uart_tx,
  output logic        irq_empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q;
  logic [7:0]     shift_q;
  logic [15:0]    per_q;     // DIVISOR latched for the current frame
  logic [15:0]    cnt_q;     // clocks elapsed in the current bit
  logic [2:0]     bit_q;
  logic           tx_q;
  logic           irq_q;
  logic [15:0]    div_q;
  logic           ovf_q;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  logic wr_txdata, wr_status, wr_div;
  logic fifo_empty, fifo_full, period_end, pop, push_ok, ovf_set, busy;
  logic [7:0] head;
  logic [3:0] count4;

  // Bits of the bus that no register uses.
  logic unused_bits;
  assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

  assign wr_txdata  = io_en & io_we & (io_addr[7:2] == 6'd0);
  assign wr_status  = io_en & io_we & (io_addr[7:2] == 6'd1);
  assign wr_div     = io_en & io_we & (io_addr[7:2] == 6'd2);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign period_end = (cnt_q == per_q);
  assign busy       = (state_q != IDLE);
  assign head       = mem_q[rd_ptr_q];
  assign count4     = 4'(count_q);

  // A pop is gated by non-empty, so a push into an empty FIFO is never
  // cancelled by a pop in the same cycle.
  assign pop     = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && period_end));
  // A pop frees a slot in the same cycle, so a push to a full FIFO that
  // coincides with a pop is accepted.
  assign push_ok = wr_txdata && (!fifo_full || pop);
  assign ovf_set = wr_txdata && fifo_full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage has no reset. The reset pointers and count make it empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= io_data_write[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (wr_status)    ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (wr_div) div_q <= io_data_write[15:0];
    end
  end

  // Serializer. uart_tx and irq_empty are registered outputs of this FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      irq_q <= fifo_empty && (state_q == IDLE);
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            per_q   <= div_q;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (period_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (period_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (period_end) begin
            cnt_q <= '0;
            if (pop) begin
              // Back-to-back frame: no idle gap after the stop bit.
              shift_q <= head;
              per_q   <= div_q;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    io_data_read = '0;
    case (io_addr[7:2])
      6'd1: io_data_read[7:0] = {count4, ovf_q, busy, fifo_empty, fifo_full};
      6'd2: io_data_read[15:0] = div_q;
      default: io_data_read = '0;
    endcase
  end

  assign uart_tx   = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic        io_en, io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        uart_tx, irq_empty;

  int n_checks = 0;
  int n_fail   = 0;

  io_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(16'd867)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read),
    .uart_tx(uart_tx), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after a rising edge. The write lands on the next edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_data_write = d; io_en = 1'b1; io_we = 1'b1;
    @(posedge clk); #1;
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    io_addr = a; #1; d = io_data_read;
  endtask

  // Reference line model: each byte gives a 10-bit frame (start, 8 data bits
  // LSB first, stop). Each bit lasts d+1 clocks. Frames follow with no gap.
  // The model expects n_idle idle samples first. After the frames it expects
  // idle with busy low, and irq_empty rising one clock later.
  task automatic expect_line(input logic [7:0] q[$], input int d, input int n_idle);
    logic [9:0]  fr;
    logic [31:0] st;
    for (int i = 0; i < n_idle; i++) begin
      @(negedge clk);
      n_checks++;
      if (uart_tx !== 1'b1) begin
        n_fail++; $display("FAIL idle_before_frame: uart_tx=%b expected 1", uart_tx);
      end
    end
    foreach (q[k]) begin
      fr = {1'b1, q[k], 1'b0};
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c <= d; c++) begin
          @(negedge clk);
          n_checks++;
          if (uart_tx !== fr[b]) begin
            n_fail++;
            $display("FAIL line_bit: frame %0d (0x%02h) bit %0d clk %0d uart_tx=%b expected %b",
                     k, q[k], b, c, uart_tx, fr[b]);
          end
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (uart_tx !== 1'b1 || irq_empty !== 1'b0) begin
      n_fail++; $display("FAIL after_stop: uart_tx=%b irq_empty=%b expected 1/0", uart_tx, irq_empty);
    end
    rd(8'h04, st);
    n_checks++;
    if (st !== 32'h2) begin
      n_fail++; $display("FAIL status_after_drain: got 0x%08h expected 0x00000002", st);
    end
    @(negedge clk);
    n_checks++;
    if (irq_empty !== 1'b1) begin
      n_fail++; $display("FAIL irq_empty_rise: got %b expected 1", irq_empty);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rd(8'h04, v); n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL reset_status: got 0x%08h expected 0x00000002", v); end
    rd(8'h08, v); n_checks++;
    if (v !== 32'h363) begin n_fail++; $display("FAIL reset_divisor: got 0x%08h expected 0x00000363", v); end
    n_checks++;
    if (uart_tx !== 1'b1 || irq_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_outputs: uart_tx=%b irq_empty=%b expected 1/1", uart_tx, irq_empty);
    end
  endtask

  task automatic test_regs;
    logic [31:0] v;
    @(posedge clk); #1;
    wr(8'h08, 32'hFFFF_0003);
    rd(8'h08, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL divisor_upper_ignored: got 0x%08h expected 0x00000003", v); end
    wr(8'h0C, 32'hDEAD_BEEF);
    rd(8'h08, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL unmapped_write: divisor 0x%08h expected 0x00000003", v); end
    rd(8'h0C, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got 0x%08h expected 0", v); end
    rd(8'h00, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got 0x%08h expected 0", v); end
    rd(8'h0B, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL addr_low_ignored: got 0x%08h expected 0x00000003", v); end
  endtask

  task automatic test_single_a5;
    logic [7:0]  q[$];
    logic [31:0] v;
    q = {8'hA5};
    @(posedge clk); #1;
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h0000_00A5);
    rd(8'h04, v); n_checks++;
    if (v !== 32'h10) begin n_fail++; $display("FAIL status_after_push: got 0x%08h expected 0x00000010", v); end
    expect_line(q, 3, 1);
  endtask

  task automatic test_back_to_back;
    logic [7:0]  q[$];
    logic [31:0] v;
    q = {8'h55, 8'h0F, 8'hF0};
    @(posedge clk); #1;
    wr(8'h08, 32'd0);
    fork
      begin
        wr(8'h00, 32'h55); wr(8'h00, 32'h0F); wr(8'h00, 32'hF0);
        rd(8'h04, v); n_checks++;
        // One byte already popped into the first frame, two queued, busy.
        if (v !== 32'h24) begin n_fail++; $display("FAIL b2b_status: got 0x%08h expected 0x00000024", v); end
      end
      expect_line(q, 0, 2);
    join
  endtask

  task automatic test_overflow;
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic [31:0] v;
    q = {};
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    @(posedge clk); #1;
    wr(8'h08, 32'd7);
    fork
      begin
        for (int i = 0; i < 5; i++) wr(8'h00, {24'h0, q[i]});
        b = ~q[4];
        wr(8'h00, {24'h0, b});
        rd(8'h04, v); n_checks++;
        if (v !== 32'h4D) begin n_fail++; $display("FAIL overflow_status: got 0x%08h expected 0x0000004D", v); end
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h04, v); n_checks++;
        if (v !== 32'h45) begin n_fail++; $display("FAIL overflow_clear: got 0x%08h expected 0x00000045", v); end
      end
      expect_line(q, 7, 2);
    join
  endtask

  task automatic test_full_push_pop;
    logic [7:0]  q[$];
    logic [31:0] v;
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    @(posedge clk); #1;
    wr(8'h08, 32'd1);
    fork
      begin
        for (int i = 0; i < 5; i++) wr(8'h00, {24'h0, q[i]});
        // The first frame started one edge after the first push and lasts 20 clocks.
        // Its end edge is 21 edges after the first push.
        repeat (16) @(posedge clk);
        #1;
        rd(8'h04, v); n_checks++;
        if (v !== 32'h45) begin n_fail++; $display("FAIL full_before: got 0x%08h expected 0x00000045", v); end
        wr(8'h00, {24'h0, q[5]});
        rd(8'h04, v); n_checks++;
        if (v !== 32'h45) begin n_fail++; $display("FAIL full_push_pop: got 0x%08h expected 0x00000045", v); end
      end
      expect_line(q, 1, 2);
    join
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    int d, n;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      @(posedge clk); #1;
      wr(8'h08, d);
      fork
        begin
          for (int i = 0; i < n; i++) wr(8'h00, {24'h0, q[i]});
        end
        expect_line(q, d, 2);
      join
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0]  q[$];
    logic [31:0] v;
    @(posedge clk); #1;
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h81);
    // Data bit 3 spans edges N+17..N+21 after the push edge N.
    repeat (17) @(posedge clk);
    #3;
    n_checks++;
    if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_bit3: uart_tx=%b expected 0", uart_tx); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (uart_tx !== 1'b1 || irq_empty !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: uart_tx=%b irq_empty=%b expected 1/1", uart_tx, irq_empty);
    end
    rd(8'h04, v); n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL reset_mid_status: got 0x%08h expected 0x00000002", v); end
    rd(8'h08, v); n_checks++;
    if (v !== 32'h363) begin n_fail++; $display("FAIL reset_mid_divisor: got 0x%08h expected 0x00000363", v); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    wr(8'h08, 32'd2);
    q = {8'($urandom)};
    wr(8'h00, {24'h0, q[0]});
    expect_line(q, 2, 1);
  endtask

  initial begin
    test_reset;
    test_regs;
    test_single_a5;
    test_back_to_back;
    test_overflow;
    test_full_push_pop;
    test_random;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
